// File: rtl/apb_master.sv
// APB initiator: valid/ready request -> APB SETUP/ACCESS -> valid/ready response.
// Optional ACCESS wait-state timeout enabled by defining APB_MST_TIMEOUT_EN.
module apb_master #(
  parameter int a_w  = 8,
  parameter int to_c = 16
) (
  input  logic           pclk,
  input  logic           prst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [a_w-1:0] req_addr,
  input  logic           req_we,
  input  logic [31:0]    req_wdata,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [31:0]    rsp_rdata,
  output logic           rsp_err,
  output logic [a_w-1:0] paddr,
  output logic [31:0]    pwdata,
  output logic           pwrite,
  output logic           psel,
  output logic           penable,
  input  logic [31:0]    prdata,
  input  logic           pready
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t         state, state_d;
  logic           rdy_d, psel_d, pen_d, wr_d, rv_d, er_d;
  logic [a_w-1:0] addr_d;
  logic [31:0]    wd_d, rd_d;

`ifdef APB_MST_TIMEOUT_EN
  localparam int cw = $clog2(to_c + 1);
  logic [cw-1:0] cnt, cnt_d;
`else
  logic unused_to;
  assign unused_to = (to_c >= 1);
`endif

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_MST_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_d;
      req_ready <= rdy_d;
      psel      <= psel_d;
      penable   <= pen_d;
      paddr     <= addr_d;
      pwdata    <= wd_d;
      pwrite    <= wr_d;
      rsp_valid <= rv_d;
      rsp_rdata <= rd_d;
      rsp_err   <= er_d;
`ifdef APB_MST_TIMEOUT_EN
      cnt       <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    rdy_d   = 1'b0;
    psel_d  = 1'b0;
    pen_d   = 1'b0;
    addr_d  = paddr;
    wd_d    = pwdata;
    wr_d    = pwrite;
    rv_d    = 1'b0;
    rd_d    = rsp_rdata;
    er_d    = rsp_err;
`ifdef APB_MST_TIMEOUT_EN
    cnt_d   = cnt;
`endif
    unique case (state)
      IDLE: begin
        rdy_d = 1'b1;
        // req_ready is registered, so it gates acceptance right after reset
        if (req_valid && req_ready) begin
          state_d = SETUP;
          rdy_d   = 1'b0;
          psel_d  = 1'b1;
          addr_d  = req_addr;
          wr_d    = req_we;
          if (req_we) wd_d = req_wdata;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        psel_d  = 1'b1;
        pen_d   = 1'b1;
`ifdef APB_MST_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ACCESS: begin
        psel_d = 1'b1;
        pen_d  = 1'b1;
        if (pready) begin
          state_d = RESP;
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rv_d    = 1'b1;
          rd_d    = pwrite ? 32'h0 : prdata;
          er_d    = 1'b0;
        end
`ifdef APB_MST_TIMEOUT_EN
        else if (cnt == cw'(to_c - 1)) begin
          state_d = RESP;
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rv_d    = 1'b1;
          rd_d    = 32'h0;
          er_d    = 1'b1;
        end else begin
          cnt_d = cnt + cw'(1);
        end
`endif
      end
      RESP: begin
        rv_d = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
          rv_d    = 1'b0;
          rdy_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
